// File: rtl/gate_exhaustive_checker_pkg.sv
// Shared definitions for the exhaustive gate checker.
//   state_t      : checker FSM states (IDLE=0, DRIVE=1, SETTLE=2, SAMPLE=3, DONE=4)
//   TT_*         : 2-input truth tables, bit i = expected output for input vector i
//   is_mismatch  : 4-state comparison, so X/Z on the gate output never reads as a pass
package gate_exhaustive_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  function automatic logic is_mismatch(input logic observed, input logic expected);
    return (observed !== expected);
  endfunction

endpackage

// File: rtl/gate_exhaustive_checker_settle_timer.sv
// settle_timer: load/count/expire counter that times the settle interval
// between driving a vector and sampling the gate output.
//   clk, rst : clock and synchronous active-high reset
//   load     : clear the count to 0
//   en       : increment the count
//   expired  : count has reached SETTLE_CYC-1
module settle_timer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(SETTLE_CYC - 1));

endmodule

// File: rtl/gate_exhaustive_checker.sv
// gate_exhaustive_checker: drives every input vector to a small combinational
// gate under test, waits a settle interval, samples its output against a truth
// table and reports a pass/fail summary.
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   start       : begin one sweep (only honoured in IDLE)
//   dut_in      : gate inputs, MSB = first gate input
//   dut_out     : gate output (may be 0/1/X/Z)
//   busy        : sweep in progress
//   done        : one-cycle pulse at the end of a sweep
//   pass        : last sweep had no mismatches (held until next start)
//   err_count   : mismatches in current/last sweep, saturating
//   fail_valid  : one-cycle pulse following each mismatching sample
//   fail_vec    : vector of the first mismatch in the sweep (held)
module gate_exhaustive_checker
  import gate_exhaustive_checker_pkg::*;
#(
  parameter int unsigned              N_IN       = 2,
  parameter logic [(2**N_IN)-1:0]     TRUTH      = TT_NOR,
  parameter int unsigned              SETTLE_CYC = 4,
  parameter int unsigned              ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  state_t          state;
  state_t          state_nxt;
  logic [N_IN-1:0] index;
  logic            timer_load;
  logic            timer_en;
  logic            timer_expired;
  logic            mismatch;

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    mismatch   = is_mismatch(dut_out, TRUTH[index]);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        timer_load = 1'b1;
        state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expired) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (index == '1) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index      <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done       <= 1'b0;
      fail_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            index     <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            busy      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          dut_in <= index;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_valid <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + ERR_W'(1);
            end
            // err_count saturates rather than wraps, so zero means no
            // earlier mismatch in this sweep.
            if (err_count == '0) begin
              fail_vec <= index;
            end
          end
          if (index != '1) begin
            index <= index + N_IN'(1);
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_count == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Directed testbench for gate_exhaustive_checker.
//   u_a : default NOR checker, GUT is a NOR or a stuck-at-1 output
//   u_b : AND checker, GUT output floats for vector 11
//   u_c : 3-input checker with ERR_W=2, all-zero truth table, GUT stuck at 1
module tb_gate_exhaustive_checker;
  import gate_exhaustive_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       start_a, dut_out_a, busy_a, done_a, pass_a, fail_valid_a, force_one_a;
  logic [1:0] dut_in_a, fvec_a;
  logic [7:0] err_a;

  logic       start_b, busy_b, done_b, pass_b, fail_valid_b;
  wire        dut_out_b;
  logic [1:0] dut_in_b, fvec_b;
  logic [7:0] err_b;

  logic       start_c, dut_out_c, busy_c, done_c, pass_c, fail_valid_c;
  logic [2:0] dut_in_c, fvec_c;
  logic [1:0] err_c;

  assign dut_out_a = force_one_a ? 1'b1 : ~(dut_in_a[1] | dut_in_a[0]);
  assign dut_out_b = (dut_in_b == 2'b11) ? 1'bz : (dut_in_b[1] & dut_in_b[0]);
  assign dut_out_c = 1'b1;

  gate_exhaustive_checker u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fail_valid_a), .fail_vec(fvec_a)
  );

  gate_exhaustive_checker #(.TRUTH(TT_AND)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fail_valid_b), .fail_vec(fvec_b)
  );

  gate_exhaustive_checker #(.N_IN(3), .TRUTH(8'h00), .SETTLE_CYC(4), .ERR_W(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_valid(fail_valid_c), .fail_vec(fvec_c)
  );

  // Observations of u_a, indexed by cycle number (edge that accepts start = cycle 0)
  int         done_cyc_q[$];
  int         fv_cyc_q[$];
  logic [1:0] din_log  [0:127];
  logic       busy_log [0:127];

  task automatic sweep_a(input int ncyc, input bit hold, input int rp1, input int rp2);
    done_cyc_q.delete();
    fv_cyc_q.delete();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = hold;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (done_a) done_cyc_q.push_back(c);
      if (fail_valid_a) fv_cyc_q.push_back(c);
      if (c < 128) begin
        din_log[c]  = dut_in_a;
        busy_log[c] = busy_a;
      end
      start_a = hold || (c == rp1) || (c == rp2);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, pass_a, fail_valid_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy_a, done_a, pass_a, fail_valid_a});
    end
    n_checks++;
    if ({err_a, fvec_a, dut_in_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 000", {err_a, fvec_a, dut_in_a});
    end
    n_checks++;
    if ({err_c, fvec_c, dut_in_c, busy_c, pass_c} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_c: got %h expected 000", {err_c, fvec_c, dut_in_c, busy_c, pass_c});
    end
    rst = 1'b0;
  endtask

  task automatic test_good_nor();
    logic [1:0] exp_din;
    force_one_a = 1'b0;
    sweep_a(30, 1'b0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      exp_din = 2'(k);
      n_checks++;
      if (din_log[6*k+3] !== exp_din) begin
        n_fail++;
        $display("FAIL nor_din_walk[%0d]: got %b expected %b", k, din_log[6*k+3], exp_din);
      end
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 25) begin
      n_fail++;
      $display("FAIL nor_done_cycle: got count %0d first %0d expected count 1 at 25",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
    end
    n_checks++;
    if (busy_log[1] !== 1'b1 || busy_log[24] !== 1'b1 || busy_log[25] !== 1'b0) begin
      n_fail++;
      $display("FAIL nor_busy: got %b%b%b expected 110", busy_log[1], busy_log[24], busy_log[25]);
    end
    n_checks++;
    if (fv_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL nor_fail_valid: got %0d pulses expected 0", fv_cyc_q.size());
    end
    n_checks++;
    if (pass_a !== 1'b1 || err_a !== 8'd0) begin
      n_fail++;
      $display("FAIL nor_result: got pass=%b err=%0d expected pass=1 err=0", pass_a, err_a);
    end
  endtask

  task automatic test_stuck_one();
    force_one_a = 1'b1;
    sweep_a(30, 1'b0, -1, -1);
    n_checks++;
    if (fv_cyc_q.size() != 3 || fv_cyc_q[0] != 12 || fv_cyc_q[1] != 18 || fv_cyc_q[2] != 24) begin
      n_fail++;
      $display("FAIL stuck_fail_valid: got %0d pulses (first %0d) expected cycles 12,18,24",
               fv_cyc_q.size(), (fv_cyc_q.size() > 0) ? fv_cyc_q[0] : -1);
    end
    n_checks++;
    if (err_a !== 8'd3 || fvec_a !== 2'b01 || pass_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_result: got err=%0d fvec=%b pass=%b expected err=3 fvec=01 pass=0",
               err_a, fvec_a, pass_a);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 25) begin
      n_fail++;
      $display("FAIL stuck_done: got count %0d expected 1 at cycle 25", done_cyc_q.size());
    end
    force_one_a = 1'b0;
  endtask

  task automatic test_floating();
    int nfv;
    int fv_at;
    int dn_at;
    nfv = 0; fv_at = -1; dn_at = -1;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (fail_valid_b) begin nfv++; fv_at = c; end
      if (done_b && dn_at < 0) dn_at = c;
    end
    n_checks++;
    if (nfv != 1 || fv_at != 24) begin
      n_fail++;
      $display("FAIL float_fail_valid: got %0d pulses last at %0d expected 1 at 24", nfv, fv_at);
    end
    n_checks++;
    if (err_b !== 8'd1 || fvec_b !== 2'b11 || pass_b !== 1'b0) begin
      n_fail++;
      $display("FAIL float_result: got err=%0d fvec=%b pass=%b expected err=1 fvec=11 pass=0",
               err_b, fvec_b, pass_b);
    end
    n_checks++;
    if (dn_at != 25 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL float_done: got done at %0d busy=%b expected 25 busy=0", dn_at, busy_b);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int ndone;
    force_one_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    n_checks++;
    if (dut_in_a !== 2'b10 || err_a !== 8'd1 || fvec_a !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_pre: got din=%b err=%0d fvec=%b expected din=10 err=1 fvec=01",
               dut_in_a, err_a, fvec_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy_a, done_a, pass_a, fail_valid_a, err_a, fvec_a, dut_in_a} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0000",
               {busy_a, done_a, pass_a, fail_valid_a, err_a, fvec_a, dut_in_a});
    end
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d active cycles expected 0", ndone);
    end
    force_one_a = 1'b0;
    sweep_a(30, 1'b0, -1, -1);
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 25 || pass_a !== 1'b1 || err_a !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_fresh: got dones=%0d pass=%b err=%0d expected 1 done at 25 pass=1 err=0",
               done_cyc_q.size(), pass_a, err_a);
    end
  endtask

  task automatic test_back_to_back();
    sweep_a(60, 1'b0, 3, 24);
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 25) begin
      n_fail++;
      $display("FAIL restart_ignored: got %0d dones (first %0d) expected 1 at 25",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
    end
    n_checks++;
    if (busy_log[30] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_busy: got busy=%b at cycle 30 expected 0", busy_log[30]);
    end
    sweep_a(77, 1'b1, -1, -1);
    n_checks++;
    if (done_cyc_q.size() != 3 || done_cyc_q[0] != 25 || done_cyc_q[1] != 51 || done_cyc_q[2] != 77) begin
      n_fail++;
      $display("FAIL held_start_dones: got %0d dones (first %0d) expected cycles 25,51,77",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
    end
    n_checks++;
    if (pass_a !== 1'b1 || err_a !== 8'd0) begin
      n_fail++;
      $display("FAIL held_start_result: got pass=%b err=%0d expected pass=1 err=0", pass_a, err_a);
    end
  endtask

  task automatic test_saturation();
    int nfv;
    int dn_at;
    nfv = 0; dn_at = -1;
    @(posedge clk); #1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      @(posedge clk); #1;
      if (fail_valid_c) nfv++;
      if (done_c && dn_at < 0) dn_at = c;
    end
    n_checks++;
    if (nfv != 8) begin
      n_fail++;
      $display("FAIL sat_fail_valid: got %0d pulses expected 8", nfv);
    end
    n_checks++;
    if (err_c !== 2'd3 || pass_c !== 1'b0 || fvec_c !== 3'b000) begin
      n_fail++;
      $display("FAIL sat_result: got err=%0d pass=%b fvec=%b expected err=3 pass=0 fvec=000",
               err_c, pass_c, fvec_c);
    end
    n_checks++;
    if (dn_at != 49 || busy_c !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_done: got done at %0d busy=%b expected 49 busy=0", dn_at, busy_c);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_a     = 1'b0;
    start_b     = 1'b0;
    start_c     = 1'b0;
    force_one_a = 1'b0;
    test_reset();
    test_good_nor();
    test_stuck_one();
    test_floating();
    test_reset_mid_sweep();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
